// File: rtl/ser_pkg.sv
// Shared types and line levels for the word serializer.
// The FSM encoding and the fixed start/stop/idle levels live here so the top and the bench agree on them.
package ser_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } ser_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/word_serializer_if.sv
// Handshake and serial-line bundle for word_serializer.
// The upstream producer uses the master modport; the serializer uses the slave modport.
interface word_serializer_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data_i;
  logic              data_val_i;
  logic              data_rdy_o;
  logic              ser_o;
  logic              busy_o;

  modport master (
    output data_i,
    output data_val_i,
    input  data_rdy_o,
    input  ser_o,
    input  busy_o
  );

  modport slave (
    input  data_i,
    input  data_val_i,
    output data_rdy_o,
    output ser_o,
    output busy_o
  );

endinterface

// File: rtl/ser_bit_timer.sv
// Free-running bit timer: counts 0..BIT_CYCLES-1 and flags the last clock of each bit.
// clr_i restarts the count so that a new frame begins on a fresh bit boundary.
module ser_bit_timer #(
  parameter int BIT_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int                 CNT_W    = $clog2(BIT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(BIT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign bit_end_o = (cnt_q == CNT_LAST);

  // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  // NOTE: state flops use non-blocking assignments only; blocking here would race other always_ff readers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial framer: start bit, DATA_W data bits LSB first, stop bit, each held BIT_CYCLES clocks.
// ser_o comes straight from a flop, so the next line level is computed one cycle ahead in ser_d.
module word_serializer
  import ser_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 4
) (
  input logic               clk_i,
  input logic               rst_i,
  word_serializer_if.slave  bus
);

  localparam int               IDX_W    = $clog2(DATA_W + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  ser_state_t        state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic              ser_q,   ser_d;
  logic              timer_clr;
  logic              bit_end;

  ser_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES)
  ) u_bit_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (timer_clr),
    .bit_end_o (bit_end)
  );

  assign bus.data_rdy_o = (state_q == IDLE);
  assign bus.busy_o     = ~bus.data_rdy_o;
  assign bus.ser_o      = ser_q;

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    idx_d     = idx_q;
    ser_d     = ser_q;
    timer_clr = 1'b0;

    unique case (state_q)
      IDLE: begin
        ser_d = IDLE_LEVEL;
        // Ready is the IDLE decode itself, so valid alone qualifies the accept here.
        if (bus.data_val_i) begin
          shreg_d   = bus.data_i;
          timer_clr = 1'b1;
          state_d   = START;
          ser_d     = START_BIT;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          ser_d   = shreg_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == IDX_LAST) begin
            state_d = STOP;
            ser_d   = STOP_BIT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_q >> 1;
            ser_d   = shreg_d[0];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          ser_d   = IDLE_LEVEL;
        end
      end
      default: begin
        state_d = IDLE;
        ser_d   = IDLE_LEVEL;
      end
    endcase
  end

  // NOTE: the shift register is a plain datapath register, so it is cleared on reset like the rest.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      ser_q   <= IDLE_LEVEL;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      ser_q   <= ser_d;
    end
  end

endmodule
